// File: rtl/serial_deserializer_if.sv
// Bus bundle for serial_deserializer: serial input side, parallel output handshake and status.
interface serial_deserializer_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             ser_in;
  logic             ser_valid;
  logic             frame_start;
  logic             lsb_first;
  logic             data_ready;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             busy;
  logic [CW-1:0]    bit_count;
  logic             overrun;
  logic             frame_err;

  modport master (
    output ser_in, ser_valid, frame_start, lsb_first, data_ready,
    input  data_out, data_valid, busy, bit_count, overrun, frame_err
  );

  modport slave (
    input  ser_in, ser_valid, frame_start, lsb_first, data_ready,
    output data_out, data_valid, busy, bit_count, overrun, frame_err
  );
endinterface

// File: rtl/serial_deserializer.sv
// Framed serial-to-parallel converter with selectable bit order, valid/ready output
// handshake, sticky overrun flag and abort detection.
module serial_deserializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_deserializer_if.slave  bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             lsb_q, lsb_d;
  logic             dv_q, dv_d;
  logic             ov_q, ov_d;
  logic             fe_q, fe_d;
  logic             last_bit;
  logic             complete;

  // Shift direction follows the order latched at frame start, not the live input.
  always_comb begin
    if (lsb_q) shifted = {bus.ser_in, sr_q[WIDTH-1:1]};
    else       shifted = {sr_q[WIDTH-2:0], bus.ser_in};
  end

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      lsb_q   <= 1'b0;
      dv_q    <= 1'b0;
      ov_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      lsb_q   <= lsb_d;
      dv_q    <= dv_d;
      ov_q    <= ov_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    dout_d   = dout_q;
    cnt_d    = cnt_q;
    lsb_d    = lsb_q;
    dv_d     = dv_q;
    ov_d     = ov_q;
    fe_d     = 1'b0;
    complete = 1'b0;

    if (dv_q && bus.data_ready) dv_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.ser_valid && bus.frame_start) begin
          state_d = SHIFT;
          lsb_d   = bus.lsb_first;
          cnt_d   = CW'(1);
          sr_d    = '0;
          if (bus.lsb_first) sr_d[WIDTH-1] = bus.ser_in;
          else               sr_d[0]       = bus.ser_in;
        end
      end
      SHIFT: begin
        if (bus.ser_valid) begin
          // A restart wins over completion, even on the last bit of the frame.
          if (bus.frame_start) begin
            fe_d  = 1'b1;
            lsb_d = bus.lsb_first;
            cnt_d = CW'(1);
            sr_d  = '0;
            if (bus.lsb_first) sr_d[WIDTH-1] = bus.ser_in;
            else               sr_d[0]       = bus.ser_in;
          end else if (last_bit) begin
            complete = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
            sr_d     = shifted;
          end else begin
            sr_d  = shifted;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A word may land when the holding register is empty or being drained this cycle.
    if (complete) begin
      if (!dv_q || bus.data_ready) begin
        dout_d = shifted;
        dv_d   = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  assign bus.data_out   = dout_q;
  assign bus.data_valid = dv_q;
  assign bus.busy       = (state_q == SHIFT);
  assign bus.bit_count  = cnt_q;
  assign bus.overrun    = ov_q;
  assign bus.frame_err  = fe_q;
endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer: frame-level model checked every cycle plus literal checks.
module tb_serial_deserializer;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;

  serial_deserializer_if #(.WIDTH(W)) bus ();
  serial_deserializer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: collect bits, build the word by positional weights at completion.
  bit             live = 0;
  bit             m_in = 0, m_order = 0, m_dv = 0, m_ov = 0, m_fe = 0;
  int             m_nb = 0;
  logic [W-1:0]   m_dout = '0;
  bit             m_bits [W];

  always @(posedge clk) begin : model
    bit           done;
    bit           dv_old;
    logic [W-1:0] word;
    if (rst) begin
      live = 1; m_in = 0; m_order = 0; m_dv = 0; m_ov = 0; m_fe = 0; m_nb = 0; m_dout = '0;
    end else begin
      done = 0; word = '0; m_fe = 0; dv_old = m_dv;
      if (bus.ser_valid) begin
        if (bus.frame_start) begin
          m_fe = m_in; m_in = 1; m_order = bus.lsb_first; m_bits[0] = bus.ser_in; m_nb = 1;
        end else if (m_in) begin
          m_bits[m_nb] = bus.ser_in;
          m_nb++;
          if (m_nb == W) begin
            for (int i = 0; i < W; i++)
              if (m_bits[i]) word = word + (m_order ? (W'(1) << i) : (W'(1) << (W - 1 - i)));
            done = 1; m_in = 0; m_nb = 0;
          end
        end
      end
      if (dv_old && bus.data_ready) m_dv = 0;
      if (done) begin
        if (!dv_old || bus.data_ready) begin m_dout = word; m_dv = 1; end
        else m_ov = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("m_data_valid", bus.data_valid, m_dv);
      check("m_busy", bus.busy, m_in);
      check("m_bit_count", bus.bit_count, m_nb);
      check("m_overrun", bus.overrun, m_ov);
      check("m_frame_err", bus.frame_err, m_fe);
      if (m_dv) check("m_data_out", bus.data_out, m_dout);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit b, input bit fs, input bit lsb, input bit rdy);
    bus.ser_valid = 1; bus.ser_in = b; bus.frame_start = fs; bus.lsb_first = lsb; bus.data_ready = rdy;
    step();
    bus.ser_valid = 0; bus.frame_start = 0; bus.data_ready = 0;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      bus.ser_valid = 0; bus.frame_start = 0; bus.data_ready = rdy;
      step();
    end
    bus.data_ready = 0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit lsb, input bit rdy_last);
    for (int i = 0; i < W; i++)
      send(w[lsb ? i : W - 1 - i], i == 0, lsb, rdy_last && (i == W - 1));
  endtask

  int pat [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

  initial begin
    rst = 1;
    bus.ser_in = 0; bus.ser_valid = 0; bus.frame_start = 0; bus.lsb_first = 0; bus.data_ready = 0;
    step(); step();
    rst = 0;
    check("rst_data_valid", bus.data_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_bit_count", bus.bit_count, 0);
    check("rst_data_out", bus.data_out, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_frame_err", bus.frame_err, 0);

    // LSB-first A5
    for (int i = 0; i < 8; i++) begin
      send(pat[i][0], i == 0, 1, 0);
      if (i == 0) begin check("lsb_busy", bus.busy, 1); check("lsb_cnt1", bus.bit_count, 1); end
      if (i == 6) begin check("lsb_cnt7", bus.bit_count, 7); check("lsb_dv_early", bus.data_valid, 0); end
    end
    check("lsb_data", bus.data_out, 8'hA5);
    check("lsb_dv", bus.data_valid, 1);
    check("lsb_idle", bus.busy, 0);
    idle(1, 1);
    check("lsb_accept", bus.data_valid, 0);

    // MSB-first A5 with gaps
    for (int i = 0; i < 8; i++) begin
      send(pat[i][0], i == 0, 0, 0);
      if (i == 1 || i == 4) begin
        idle(1, 0);
        check("gap_cnt", bus.bit_count, i + 1);
      end
    end
    check("msb_data", bus.data_out, 8'hA5);
    check("msb_dv", bus.data_valid, 1);

    // Completion coinciding with accept: new word, no overrun
    send_word(8'h12, 1, 1);
    check("acc_data", bus.data_out, 8'h12);
    check("acc_dv", bus.data_valid, 1);
    check("acc_ov", bus.overrun, 0);
    idle(1, 1);

    // lsb_first toggled mid-frame is ignored
    for (int i = 0; i < 8; i++) send(i < 2, i == 0, i >= 2, 0);
    check("order_latch", bus.data_out, 8'hC0);
    idle(1, 1);

    // Backpressure
    send_word(8'h3C, 1, 0);
    check("bp_first", bus.data_out, 8'h3C);
    send_word(8'hC3, 1, 0);
    check("bp_hold", bus.data_out, 8'h3C);
    check("bp_ov", bus.overrun, 1);
    check("bp_dv", bus.data_valid, 1);
    idle(1, 1);
    check("bp_drain", bus.data_valid, 0);
    check("bp_ov_sticky", bus.overrun, 1);

    // Abort on bit 4, then full 81
    for (int i = 0; i < 4; i++) send(1, i == 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      send((i == 0) || (i == 7), i == 0, 1, 0);
      if (i == 0) begin check("abort_fe", bus.frame_err, 1); check("abort_cnt", bus.bit_count, 1); end
      if (i == 1) check("abort_fe_pulse", bus.frame_err, 0);
    end
    check("abort_data", bus.data_out, 8'h81);
    idle(1, 1);

    // Restart on the would-be completing bit
    for (int i = 0; i < 7; i++) send(0, i == 0, 0, 0);
    send(1, 1, 0, 0);
    check("late_fe", bus.frame_err, 1);
    check("late_dv", bus.data_valid, 0);
    check("late_cnt", bus.bit_count, 1);
    for (int i = 0; i < 7; i++) send(i == 6, 0, 0, 0);
    check("late_data", bus.data_out, 8'h81);
    idle(1, 1);

    // Reset mid-frame
    for (int i = 0; i < 5; i++) send(1, i == 0, 1, 0);
    check("pre_rst_cnt", bus.bit_count, 5);
    rst = 1;
    step();
    rst = 0;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_cnt", bus.bit_count, 0);
    check("mid_rst_fe", bus.frame_err, 0);
    check("mid_rst_ov", bus.overrun, 0);
    for (int i = 0; i < 10; i++) send(1, 0, 1, 0);
    check("post_rst_dv", bus.data_valid, 0);
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_cnt", bus.bit_count, 0);
    idle(3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_deserializer.md
SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 Parameter: WIDTH, 8, frame length in bits and width of data_out; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ser_in  input  1  serial data bit, sampled only when ser_valid=1.
REQ-005 ser_valid  input  1  qualifies ser_in for the current cycle.
REQ-006 frame_start  input  1  marks the current valid bit as bit 0 of a new frame; ignored when ser_valid=0.
REQ-007 lsb_first  input  1  bit order: 1 = first bit is LSB, 0 = first bit is MSB.
REQ-008 data_ready  input  1  consumer accepts data_out in cycles where data_valid=1.
REQ-009 data_out  output  WIDTH  last completed frame, registered.
REQ-010 data_valid  output  1  data_out holds an unconsumed frame.
REQ-011 busy  output  1  frame in progress (state SHIFT).
REQ-012 bit_count  output  clog2(WIDTH)  number of bits received in the current frame.
REQ-013 overrun  output  1  sticky: a completed frame was dropped.
REQ-014 frame_err  output  1  one-cycle pulse: a frame was aborted by frame_start before completion.

Function
REQ-015 The FSM SHALL have two states: IDLE and SHIFT.
REQ-016 IDLE: ser_valid=1 with frame_start=1 SHALL load bit 0, latch lsb_first for the frame, set bit_count=1, and go to SHIFT. Valid bits without frame_start SHALL be discarded.
REQ-017 SHIFT: each ser_valid=1 cycle SHALL shift in exactly one bit and increment bit_count. ser_valid=0 SHALL hold all state.
REQ-018 Latched lsb_first=1 SHALL right-shift: sr <= {ser_in, sr[WIDTH-1:1]}. After WIDTH bits, the first bit received SHALL be at data_out[0].
REQ-019 Latched lsb_first=0 SHALL left-shift: sr <= {sr[WIDTH-2:0], ser_in}. After WIDTH bits, the first bit received SHALL be at data_out[WIDTH-1].
REQ-020 Changes on lsb_first mid-frame SHALL have no effect until the next frame start.
REQ-021 Frame completion:
  - Trigger: the cycle carrying bit WIDTH-1.
  - Effect: the assembled word SHALL be written to data_out and data_valid set on the next edge.
  - State: bit_count returns to 0 and the FSM returns to IDLE.
  - Latency: last bit in to data_valid=1 is exactly one clock.
REQ-022 frame_start with ser_valid=1 while in SHIFT SHALL:
  - discard the partial frame;
  - pulse frame_err for one cycle;
  - restart with this bit as bit 0: bit_count=1, lsb_first re-latched.
REQ-023 frame_start on the completing bit (bit_count=WIDTH-1) SHALL be treated as REQ-022: abort, no completion.
REQ-024 Handshake: data_valid=1 and data_ready=1 on a clock edge SHALL clear data_valid. data_out SHALL stay stable while data_valid=1 and data_ready=0.
REQ-025 Completion in the same cycle as an accept SHALL load the new word and keep data_valid=1, with no overrun.
REQ-026 Completion while data_valid=1 and data_ready=0 SHALL drop the new word, keep data_out unchanged, and set overrun.
REQ-027 overrun SHALL clear only on rst.
REQ-028 busy SHALL be 1 exactly when the state is SHIFT.
REQ-029 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-030 rst=1 SHALL set the following at the next edge, overriding all other inputs:
  - state IDLE;
  - shift register 0 and bit_count 0;
  - data_out 0 and data_valid 0;
  - busy 0, overrun 0, frame_err 0.
REQ-031 rst asserted mid-frame SHALL discard the partial frame with no data_valid and no frame_err. The first valid bit after rst deasserts SHALL require frame_start.

Verification
REQ-032 LSB-first: frame_start on the first bit, lsb_first=1, bits 1,0,1,0,0,1,0,1 -> one cycle after the 8th bit, data_out=8'hA5 and data_valid=1.
REQ-033 MSB-first with gaps: lsb_first=0, bits 1,0,1,0,0,1,0,1 with ser_valid=0 inserted after bits 2 and 5 -> data_out=8'hA5. bit_count holds during the gaps.
REQ-034 Backpressure: data_ready=0, two complete frames 8'h3C then 8'hC3 -> data_out stays 8'h3C and overrun=1. Then data_ready=1 for one cycle -> data_valid=0 and overrun stays 1.
REQ-035 Abort: frame_start re-asserted on bit 4 of a frame, then a full frame of 8'h81 -> frame_err pulses once and data_out=8'h81.
REQ-036 Reset mid-frame: rst after 5 bits -> busy=0 and bit_count=0. Subsequent valid bits without frame_start are ignored and data_valid stays 0.
